// File: rtl/i2c_txn_arbiter_if.sv
// Client-side request/grant bundle plus byte-level master engine handshake
// for the shared I2C transaction arbiter.
interface i2c_txn_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 7,
    parameter int LEN_W  = 4
);
    logic [N_REQ-1:0]        i_req;
    logic [N_REQ*ADDR_W-1:0] i_addr;
    logic [N_REQ-1:0]        i_rw;
    logic [N_REQ*LEN_W-1:0]  i_len;
    logic [N_REQ*8-1:0]      i_wdata;
    logic [N_REQ-1:0]        o_gnt;
    logic [N_REQ-1:0]        o_wack;
    logic [N_REQ-1:0]        o_rvalid;
    logic [7:0]              o_rdata;
    logic [N_REQ-1:0]        o_done;
    logic [N_REQ-1:0]        o_err;
    logic                    o_m_start;
    logic                    o_m_abort;
    logic [ADDR_W-1:0]       o_m_addr;
    logic                    o_m_rw;
    logic [7:0]              o_m_wdata;
    logic                    o_m_last;
    logic                    i_m_byte_done;
    logic [7:0]              i_m_rdata;
    logic                    i_m_nack;
    logic                    i_m_done;

    modport slave (
        input  i_req, i_addr, i_rw, i_len, i_wdata,
        input  i_m_byte_done, i_m_rdata, i_m_nack, i_m_done,
        output o_gnt, o_wack, o_rvalid, o_rdata, o_done, o_err,
        output o_m_start, o_m_abort, o_m_addr, o_m_rw, o_m_wdata, o_m_last
    );

    modport master (
        output i_req, i_addr, i_rw, i_len, i_wdata,
        output i_m_byte_done, i_m_rdata, i_m_nack, i_m_done,
        input  o_gnt, o_wack, o_rvalid, o_rdata, o_done, o_err,
        input  o_m_start, o_m_abort, o_m_addr, o_m_rw, o_m_wdata, o_m_last
    );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one byte-level I2C master engine between
// N_REQ requesters, sequencing write/read bytes and reporting done/error.
module i2c_txn_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 7,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    i2c_txn_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ARB, LAUNCH, XFER, WAIT_DONE, REPORT} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_q, rr_d, g_q, g_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rw_q, rw_d;
    logic [LEN_W-1:0]    len_q, len_d, cnt_q, cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                tmo_fired_q, tmo_fired_d, err_q, err_d, wupd_q, wupd_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d, wack_q, wack_d, rvalid_q, rvalid_d;
    logic [N_REQ-1:0]    done_q, done_d, erro_q, erro_d;
    logic [7:0]          rdata_q, rdata_d, m_wdata_q, m_wdata_d;
    logic                m_start_q, m_start_d, m_abort_q, m_abort_d;
    logic                m_rw_q, m_rw_d, m_last_q, m_last_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;

    logic [ADDR_W-1:0]   req_addr  [N_REQ];
    logic [LEN_W-1:0]    req_len   [N_REQ];
    logic [7:0]          req_wdata [N_REQ];
    logic [2*N_REQ-1:0]  req_dbl;
    logic [IDX_W:0]      search_idx;
    logic [IDX_W-1:0]    pick;
    logic                found, byte_evt;
    logic [LEN_W-1:0]    cnt_inc;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign req_addr[gi]  = bus.i_addr[gi*ADDR_W +: ADDR_W];
        assign req_len[gi]   = bus.i_len[gi*LEN_W +: LEN_W];
        assign req_wdata[gi] = bus.i_wdata[gi*8 +: 8];
    end

    // Doubled request vector lets the search walk rr+1..rr+N_REQ without a modulo.
    assign req_dbl = {bus.i_req, bus.i_req};

    always_comb begin
        found      = 1'b0;
        pick       = '0;
        search_idx = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            search_idx = {1'b0, rr_q} + (IDX_W+1)'(i);
            if (!found && req_dbl[search_idx]) begin
                found = 1'b1;
                pick  = (search_idx >= (IDX_W+1)'(N_REQ)) ? IDX_W'(search_idx - (IDX_W+1)'(N_REQ))
                                                          : IDX_W'(search_idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        g_d         = g_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        tmo_fired_d = tmo_fired_q;
        err_d       = err_q;
        wupd_d      = 1'b0;
        gnt_d       = gnt_q;
        wack_d      = '0;
        rvalid_d    = '0;
        rdata_d     = rdata_q;
        done_d      = '0;
        erro_d      = '0;
        m_start_d   = 1'b0;
        m_abort_d   = 1'b0;
        m_addr_d    = m_addr_q;
        m_rw_d      = m_rw_q;
        m_wdata_d   = m_wdata_q;
        m_last_d    = m_last_q;
        byte_evt    = 1'b0;
        cnt_inc     = cnt_q + LEN_W'(1);

        // Requester presents its next byte in the cycle after o_wack.
        if (wupd_q) m_wdata_d = req_wdata[g_q];

        case (state_q)
            IDLE: if (|bus.i_req) state_d = ARB;
            ARB: begin
                if (found) begin
                    g_d    = pick;
                    gnt_d  = N_REQ'(1) << pick;
                    addr_d = req_addr[pick];
                    rw_d   = bus.i_rw[pick];
                    len_d  = req_len[pick];
                    if (req_len[pick] == '0) begin
                        err_d   = 1'b1;
                        state_d = REPORT;
                    end else begin
                        state_d = LAUNCH;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LAUNCH: begin
                m_start_d   = 1'b1;
                m_addr_d    = addr_q;
                m_rw_d      = rw_q;
                m_wdata_d   = req_wdata[g_q];
                m_last_d    = (len_q == LEN_W'(1));
                cnt_d       = '0;
                tmo_d       = '0;
                tmo_fired_d = 1'b0;
                state_d     = XFER;
            end
            XFER: begin
                if (bus.i_m_nack) begin
                    err_d   = 1'b1;
                    state_d = bus.i_m_done ? REPORT : WAIT_DONE;
                end else if (bus.i_m_byte_done) begin
                    byte_evt = 1'b1;
                    cnt_d    = cnt_inc;
                    tmo_d    = '0;
                    if (rw_q) begin
                        rvalid_d = gnt_q;
                        rdata_d  = bus.i_m_rdata;
                    end else begin
                        wack_d = gnt_q;
                        wupd_d = (cnt_inc != len_q);
                    end
                    m_last_d = ((len_q - cnt_inc) == LEN_W'(1));
                    if (cnt_inc == len_q) state_d = WAIT_DONE;
                end else if (bus.i_m_done) begin
                    err_d   = 1'b1;
                    state_d = REPORT;
                end
            end
            WAIT_DONE: if (bus.i_m_done) state_d = REPORT;
            REPORT: begin
                done_d  = gnt_q;
                erro_d  = err_q ? gnt_q : '0;
                gnt_d   = '0;
                rr_d    = g_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // First expiry aborts and keeps waiting for STOP; a second one gives up.
        if ((state_q == XFER || state_q == WAIT_DONE) && !byte_evt && state_d != REPORT) begin
            if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                tmo_d = '0;
                err_d = 1'b1;
                if (tmo_fired_q) begin
                    state_d = REPORT;
                end else begin
                    m_abort_d   = 1'b1;
                    tmo_fired_d = 1'b1;
                end
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            rr_q        <= IDX_W'(N_REQ - 1);
            g_q         <= '0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            tmo_fired_q <= 1'b0;
            err_q       <= 1'b0;
            wupd_q      <= 1'b0;
            gnt_q       <= '0;
            wack_q      <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            done_q      <= '0;
            erro_q      <= '0;
            m_start_q   <= 1'b0;
            m_abort_q   <= 1'b0;
            m_addr_q    <= '0;
            m_rw_q      <= 1'b0;
            m_wdata_q   <= '0;
            m_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            g_q         <= g_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            tmo_fired_q <= tmo_fired_d;
            err_q       <= err_d;
            wupd_q      <= wupd_d;
            gnt_q       <= gnt_d;
            wack_q      <= wack_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            erro_q      <= erro_d;
            m_start_q   <= m_start_d;
            m_abort_q   <= m_abort_d;
            m_addr_q    <= m_addr_d;
            m_rw_q      <= m_rw_d;
            m_wdata_q   <= m_wdata_d;
            m_last_q    <= m_last_d;
        end
    end

    assign bus.o_gnt     = gnt_q;
    assign bus.o_wack    = wack_q;
    assign bus.o_rvalid  = rvalid_q;
    assign bus.o_rdata   = rdata_q;
    assign bus.o_done    = done_q;
    assign bus.o_err     = erro_q;
    assign bus.o_m_start = m_start_q;
    assign bus.o_m_abort = m_abort_q;
    assign bus.o_m_addr  = m_addr_q;
    assign bus.o_m_rw    = m_rw_q;
    assign bus.o_m_wdata = m_wdata_q;
    assign bus.o_m_last  = m_last_q;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter: write, read, fairness, NACK, timeout,
// zero-length and mid-transfer reset, with hand-computed expectations.
module tb_i2c_txn_arbiter;
    localparam int N_REQ = 4, ADDR_W = 7, LEN_W = 4, TIMEOUT = 1023;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_txn_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    i2c_txn_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_cmp = 0, n_fail = 0;
    int n_start = 0, n_wack = 0, n_done = 0;

    always @(posedge clk) begin
        if (bus.o_m_start) n_start <= n_start + 1;
        if (|bus.o_wack)   n_wack  <= n_wack + 1;
        if (|bus.o_done)   n_done  <= n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [6:0] a, input logic rw,
                           input logic [3:0] len, input logic [7:0] wd);
        bus.i_addr[k*ADDR_W +: ADDR_W] = a;
        bus.i_rw[k]                    = rw;
        bus.i_len[k*LEN_W +: LEN_W]    = len;
        bus.i_wdata[k*8 +: 8]          = wd;
        bus.i_req[k]                   = 1'b1;
    endtask

    task automatic wait_start(output int cyc);
        cyc = 0;
        while (!bus.o_m_start && cyc < 20) begin
            tick();
            cyc++;
        end
        check("start_seen", bus.o_m_start, 1);
    endtask

    // Plays the master for an n-byte transfer and waits for the completion pulse.
    task automatic serve(input int nbytes, output logic [3:0] g, output int gap);
        int c;
        wait_start(gap);
        g = bus.o_gnt;
        for (int b = 0; b < nbytes; b++) begin
            bus.i_m_byte_done = 1'b1;
            tick();
            bus.i_m_byte_done = 1'b0;
            tick();
        end
        bus.i_m_done = 1'b1;
        tick();
        bus.i_m_done = 1'b0;
        c = 0;
        while (!(|bus.o_done) && c < 20) begin
            tick();
            c++;
        end
        check("serve_done_seen", |bus.o_done, 1);
        check("serve_err", bus.o_err, 0);
        $display("txn: gnt=%b gap=%0d done=%b", g, gap, bus.o_done);
    endtask

    initial begin : stim
        logic [3:0] g;
        int gap, n, s0, w0, d0;

        bus.i_req = '0; bus.i_addr = '0; bus.i_rw = '0; bus.i_len = '0; bus.i_wdata = '0;
        bus.i_m_byte_done = 1'b0; bus.i_m_rdata = '0; bus.i_m_nack = 1'b0; bus.i_m_done = 1'b0;
        repeat (3) tick();
        check("rst_gnt", bus.o_gnt, 0);
        check("rst_pulses", {bus.o_done, bus.o_err, bus.o_wack, bus.o_m_start, bus.o_m_abort}, 0);
        check("rst_m_addr", bus.o_m_addr, 0);
        rst_n = 1'b1;
        tick();

        // Fairness: everyone requesting, expect 0,1,2,3,0 with 3-cycle done->start spacing.
        for (int k = 0; k < 4; k++) set_req(k, 7'(8'h20 + k), 1'b0, 4'd1, 8'h00);
        for (int k = 0; k < 5; k++) begin
            serve(1, g, gap);
            check("fair_gnt", g, 32'(1 << (k % 4)));
            check("fair_gap", gap, 3);
        end
        bus.i_req = '0;
        tick();

        // Single write, requester 0.
        s0 = n_start; w0 = n_wack;
        set_req(0, 7'h50, 1'b0, 4'd3, 8'hA1);
        tick();
        check("wr_gnt_arb", bus.o_gnt, 0);
        tick();
        check("wr_gnt", bus.o_gnt, 4'b0001);
        tick();
        check("wr_start", bus.o_m_start, 1);
        check("wr_addr", bus.o_m_addr, 7'h50);
        check("wr_rw", bus.o_m_rw, 0);
        check("wr_wdata0", bus.o_m_wdata, 8'hA1);
        check("wr_last0", bus.o_m_last, 0);
        bus.i_m_byte_done = 1'b1; tick();
        check("wr_wack1", bus.o_wack, 4'b0001);
        check("wr_last1", bus.o_m_last, 0);
        bus.i_m_byte_done = 1'b0; bus.i_wdata[7:0] = 8'hB2; tick();
        check("wr_wdata1", bus.o_m_wdata, 8'hB2);
        bus.i_m_byte_done = 1'b1; tick();
        check("wr_wack2", bus.o_wack, 4'b0001);
        check("wr_last2", bus.o_m_last, 1);
        bus.i_m_byte_done = 1'b0; bus.i_wdata[7:0] = 8'hC3; tick();
        check("wr_wdata2", bus.o_m_wdata, 8'hC3);
        bus.i_m_byte_done = 1'b1; tick();
        check("wr_wack3", bus.o_wack, 4'b0001);
        check("wr_last3", bus.o_m_last, 0);
        bus.i_m_byte_done = 1'b0; bus.i_m_done = 1'b1; tick();
        bus.i_m_done = 1'b0;
        check("wr_done_early", bus.o_done, 0);
        tick();
        check("wr_done", bus.o_done, 4'b0001);
        check("wr_err", bus.o_err, 0);
        check("wr_gnt_clr", bus.o_gnt, 0);
        bus.i_req[0] = 1'b0;
        tick();
        check("wr_start_cnt", n_start - s0, 1);
        check("wr_wack_cnt", n_wack - w0, 3);
        $display("txn: write req0 len3 complete");

        // Read len 2, requester 2.
        set_req(2, 7'h3C, 1'b1, 4'd2, 8'h00);
        tick(); tick();
        check("rd_gnt", bus.o_gnt, 4'b0100);
        tick();
        check("rd_start", bus.o_m_start, 1);
        check("rd_rw", bus.o_m_rw, 1);
        check("rd_addr", bus.o_m_addr, 7'h3C);
        check("rd_last0", bus.o_m_last, 0);
        bus.i_m_rdata = 8'h5A; bus.i_m_byte_done = 1'b1; tick();
        check("rd_rvalid1", bus.o_rvalid, 4'b0100);
        check("rd_rdata1", bus.o_rdata, 8'h5A);
        check("rd_last1", bus.o_m_last, 1);
        bus.i_m_byte_done = 1'b0; tick();
        check("rd_rvalid_gap", bus.o_rvalid, 0);
        bus.i_m_rdata = 8'h7E; bus.i_m_byte_done = 1'b1; tick();
        check("rd_rvalid2", bus.o_rvalid, 4'b0100);
        check("rd_rdata2", bus.o_rdata, 8'h7E);
        bus.i_m_byte_done = 1'b0; bus.i_m_done = 1'b1; tick();
        bus.i_m_done = 1'b0; tick();
        check("rd_done", bus.o_done, 4'b0100);
        check("rd_err", bus.o_err, 0);
        bus.i_req[2] = 1'b0;
        tick();
        $display("txn: read req2 len2 complete");

        // Address NACK coinciding with byte_done, requester 1.
        set_req(1, 7'h22, 1'b0, 4'd2, 8'h11);
        wait_start(n);
        bus.i_m_nack = 1'b1; bus.i_m_byte_done = 1'b1; tick();
        check("nack_no_wack", bus.o_wack, 0);
        check("nack_no_advance", bus.o_m_last, 0);
        bus.i_m_nack = 1'b0; bus.i_m_byte_done = 1'b0; tick();
        bus.i_m_done = 1'b1; tick();
        bus.i_m_done = 1'b0; tick();
        check("nack_done", bus.o_done, 4'b0010);
        check("nack_err", bus.o_err, 4'b0010);
        bus.i_req[1] = 1'b0;
        tick();
        $display("txn: nack req1 reported");

        // Timeout: silent master, requester 3.
        set_req(3, 7'h48, 1'b0, 4'd2, 8'h99);
        wait_start(n);
        n = 0;
        while (!bus.o_m_abort && n < 1100) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, TIMEOUT);
        check("tmo_no_done_yet", bus.o_done, 0);
        tick();
        check("tmo_abort_pulse", bus.o_m_abort, 0);
        bus.i_m_done = 1'b1; tick();
        bus.i_m_done = 1'b0; tick();
        check("tmo_done", bus.o_done, 4'b1000);
        check("tmo_err", bus.o_err, 4'b1000);
        bus.i_req[3] = 1'b0;
        tick();
        $display("txn: timeout req3 reported");

        // Zero length: error without starting the master.
        s0 = n_start;
        set_req(0, 7'h10, 1'b0, 4'd0, 8'h00);
        tick(); tick();
        check("len0_gnt", bus.o_gnt, 4'b0001);
        tick();
        check("len0_done", bus.o_done, 4'b0001);
        check("len0_err", bus.o_err, 4'b0001);
        bus.i_req[0] = 1'b0;
        tick();
        check("len0_no_start", n_start - s0, 0);
        $display("txn: len0 req0 reported");

        // Reset mid-transfer, requester 2.
        set_req(2, 7'h2A, 1'b0, 4'd3, 8'h77);
        wait_start(n);
        bus.i_m_byte_done = 1'b1; tick();
        bus.i_m_byte_done = 1'b0;
        check("mid_wack", bus.o_wack, 4'b0100);
        d0 = n_done;
        rst_n = 1'b0;
        #1;
        check("mid_rst_flags", {bus.o_gnt, bus.o_wack, bus.o_rvalid, bus.o_done, bus.o_err,
                                bus.o_m_start, bus.o_m_abort, bus.o_m_rw, bus.o_m_last}, 0);
        check("mid_rst_addr", bus.o_m_addr, 0);
        check("mid_rst_wdata", bus.o_m_wdata, 0);
        check("mid_rst_rdata", bus.o_rdata, 0);
        tick(); tick();
        rst_n = 1'b1;
        set_req(0, 7'h31, 1'b0, 4'd1, 8'h55);
        serve(1, g, gap);
        check("post_rst_winner", g, 4'b0001);
        bus.i_req = '0;
        tick();
        check("post_rst_done_cnt", n_done - d0, 1);
        $display("txn: reset recovery req0 won");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
Shares one I2C byte-level master engine between N_REQ independent requesters.
- Arbitrates pending transaction requests round-robin and latches the winner's target address, direction and byte count.
- Sequences the master one byte at a time: hands over write bytes, returns read bytes, and reports completion or error to the granted requester.
- Sits between the on-chip clients and the i2c master engine (SCL/SDA generation). It never touches the bus pins.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 7, I2C target address width
LEN_W, 4, byte-count width; transaction length 1..2^LEN_W-1
TIMEOUT, 1023, max i_clk cycles allowed between master byte events before abort

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous reset, active-low
i_req  in  N_REQ  per-requester transaction request, held until matching o_done
i_addr  in  N_REQ*ADDR_W  per-requester target address (slice k = requester k)
i_rw  in  N_REQ  per-requester direction, 1=read 0=write
i_len  in  N_REQ*LEN_W  per-requester byte count
i_wdata  in  N_REQ*8  per-requester current write byte
o_gnt  out  N_REQ  one-hot grant, high for the whole transaction
o_wack  out  N_REQ  1-cycle pulse: current write byte consumed, present next byte
o_rvalid  out  N_REQ  1-cycle pulse: o_rdata valid for that requester
o_rdata  out  8  read byte (shared)
o_done  out  N_REQ  1-cycle completion pulse
o_err  out  N_REQ  1-cycle error pulse, coincident with o_done
o_m_start  out  1  1-cycle transaction start to master
o_m_abort  out  1  1-cycle abort to master (forces STOP)
o_m_addr  out  ADDR_W  target address to master
o_m_rw  out  1  direction to master
o_m_wdata  out  8  write byte to master
o_m_last  out  1  current byte is the final one (master sends NACK on read, then STOP)
i_m_byte_done  in  1  master finished one data byte (pulse)
i_m_rdata  in  8  master read byte, valid with i_m_byte_done
i_m_nack  in  1  master saw NACK on address or write byte (pulse)
i_m_done  in  1  master issued STOP and is idle (pulse)

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0, error flag 0, timeout counter 0. RR pointer = N_REQ-1, so requester 0 wins first. Reset mid-transaction drops everything immediately; no o_done is issued.
- FSM states: IDLE, ARB, LAUNCH, XFER, WAIT_DONE, REPORT.
- IDLE: any i_req bit high -> ARB next cycle.
- ARB: grant g = first requester with i_req set, searching from RR pointer+1 with wrap.
  - Latch addr, rw, len of g; set o_gnt[g].
  - If len==0: set the error flag and go to REPORT; the master is never started.
  - Otherwise go to LAUNCH. i_req is sampled only here; deassertion later is ignored.
- LAUNCH: one-cycle o_m_start with o_m_addr/o_m_rw latched and o_m_wdata = i_wdata[g]; o_m_last = (len==1). Clear counters -> XFER.
- XFER, on i_m_byte_done:
  - Byte counter +1 and timeout counter cleared.
  - Write: pulse o_wack[g]. Next cycle o_m_wdata <= i_wdata[g].
  - Read: pulse o_rvalid[g] with o_rdata <= i_m_rdata (same cycle, registered).
  - o_m_last asserts when len - count == 1. When count reaches len -> WAIT_DONE.
- i_m_nack in XFER: set the error flag -> WAIT_DONE. If it coincides with i_m_byte_done, the NACK wins: no o_wack, and the counter does not advance.
- i_m_done in XFER before count==len: set the error flag -> REPORT (premature STOP).
- Timeout: the counter increments every cycle in XFER/WAIT_DONE. When it reaches TIMEOUT: pulse o_m_abort, set the error flag, clear the counter, stay put, and wait for i_m_done. A second expiry -> REPORT unconditionally.
- WAIT_DONE: i_m_done -> REPORT.
- REPORT: pulse o_done[g], plus o_err[g] if the error flag is set. Clear o_gnt; RR pointer <= g -> IDLE. There is always at least one IDLE cycle between transactions.
- Outputs are registered; o_m_* change only in LAUNCH or on byte events. Exactly one o_gnt bit is high outside IDLE/ARB.
- Latency: i_req rising in IDLE -> o_gnt at cycle 2, o_m_start at cycle 3.

Test Plan:
- Single write: req0, addr 0x50, len 3, bytes A1/B2/C3; master byte_done ×3 then done -> o_m_start once, o_m_wdata sequence A1,B2,C3, o_m_last only on the 3rd byte, 3 o_wack[0] pulses, o_done[0]=1, o_err=0.
- Read len 2 from req2, i_m_rdata 0x5A then 0x7E -> two o_rvalid[2] pulses carrying 0x5A, 0x7E; o_m_last on the 2nd byte; o_done[2].
- Fairness: req0..req3 all held high continuously -> grant order 0,1,2,3,0 with one IDLE gap between each.
- Address NACK: i_m_nack right after o_m_start, then i_m_done -> no o_wack, o_done[1] and o_err[1] pulse together.
- Timeout and len 0: master silent for 1023 cycles -> o_m_abort pulse, then i_m_done -> o_err. Separately, len=0 -> o_err without o_m_start.
- Reset asserted mid-XFER -> all outputs 0 at once. After release, requester 0 wins first.
